// File: rtl/uart_tx_rx_sched.sv
// Bus master for the UART register block: init BAUD/CTRL, poll STATUS,
// round-robin TX among requesters and drain RX bytes to a pulse output.
module uart_tx_rx_sched #(
  parameter int          N_REQ     = 4,
  parameter logic [31:0] BAUD_DIV  = 32'h1B8,
  parameter logic [31:0] CTRL_INIT = 32'h3
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [8*N_REQ-1:0]   req_data,
  output logic [N_REQ-1:0]     req_ready,
  output logic                 rx_valid,
  output logic [7:0]           rx_data,
  output logic                 u_we,
  output logic [7:0]           u_waddr,
  output logic [31:0]          u_wdata,
  output logic [7:0]           u_raddr,
  input  logic [31:0]          u_rdata,
  output logic                 init_done,
  output logic                 tx_busy
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [3:0] S_INIT_BAUD = 4'd0;
  localparam logic [3:0] S_INIT_CTRL = 4'd1;
  localparam logic [3:0] S_POLL      = 4'd2;
  localparam logic [3:0] S_POLL_WAIT = 4'd3;
  localparam logic [3:0] S_CHECK     = 4'd4;
  localparam logic [3:0] S_RX_ADDR   = 4'd5;
  localparam logic [3:0] S_RX_WAIT   = 4'd6;
  localparam logic [3:0] S_RX_CAP    = 4'd7;
  localparam logic [3:0] S_RX_CLR    = 4'd8;
  localparam logic [3:0] S_TX_WR     = 4'd9;
  localparam logic [3:0] S_GAP       = 4'd10;

  localparam logic [7:0] A_CTRL   = 8'h00;
  localparam logic [7:0] A_STATUS = 8'h04;
  localparam logic [7:0] A_BAUD   = 8'h08;
  localparam logic [7:0] A_TXDATA = 8'h0C;
  localparam logic [7:0] A_RXDATA = 8'h10;

  logic [3:0]       state_reg;
  logic [IDX_W-1:0] rr_reg;
  logic             rx_pend_clr_reg;

  logic [IDX_W-1:0] grant_idx;
  logic             grant_found;
  logic [7:0]       grant_data;
  int               cand;

  // Rotating search starting just after the last granted requester.
  always_comb begin
    grant_idx   = rr_reg;
    grant_found = 1'b0;
    cand        = 0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = int'(rr_reg) + i;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (!grant_found && req_valid[IDX_W'(cand)]) begin
        grant_found = 1'b1;
        grant_idx   = IDX_W'(cand);
      end
    end
  end

  assign grant_data = req_data[int'(grant_idx)*8 +: 8];

  logic st_busy;
  logic st_rxov;
  assign st_busy = u_rdata[0];
  assign st_rxov = u_rdata[1];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg       <= S_INIT_BAUD;
      rr_reg          <= IDX_W'(N_REQ - 1);
      rx_pend_clr_reg <= 1'b0;
      u_we            <= 1'b0;
      u_waddr         <= 8'h00;
      u_wdata         <= 32'h0;
      u_raddr         <= A_STATUS;
      req_ready       <= '0;
      rx_valid        <= 1'b0;
      rx_data         <= 8'h00;
      init_done       <= 1'b0;
      tx_busy         <= 1'b0;
    end else begin
      u_we      <= 1'b0;
      req_ready <= '0;
      rx_valid  <= 1'b0;
      case (state_reg)
        S_INIT_BAUD: begin
          u_we      <= 1'b1;
          u_waddr   <= A_BAUD;
          u_wdata   <= BAUD_DIV;
          state_reg <= S_INIT_CTRL;
        end
        S_INIT_CTRL: begin
          u_we      <= 1'b1;
          u_waddr   <= A_CTRL;
          u_wdata   <= CTRL_INIT;
          init_done <= 1'b1;
          state_reg <= S_POLL;
        end
        S_POLL: begin
          u_raddr   <= A_STATUS;
          state_reg <= S_POLL_WAIT;
        end
        S_POLL_WAIT: state_reg <= S_CHECK;
        S_CHECK: begin
          if (st_rxov && !rx_pend_clr_reg) begin
            state_reg <= S_RX_ADDR;
          end else if (!st_busy && rx_pend_clr_reg) begin
            tx_busy   <= 1'b0;
            state_reg <= S_RX_CLR;
          end else if (!st_busy && (|req_valid)) begin
            state_reg <= S_TX_WR;
          end else begin
            tx_busy   <= st_busy;
            state_reg <= S_POLL;
          end
        end
        S_RX_ADDR: begin
          u_raddr   <= A_RXDATA;
          state_reg <= S_RX_WAIT;
        end
        S_RX_WAIT: state_reg <= S_RX_CAP;
        S_RX_CAP: begin
          rx_data         <= u_rdata[7:0];
          rx_valid        <= 1'b1;
          rx_pend_clr_reg <= 1'b1;
          state_reg       <= S_POLL;
        end
        // Only reached with the TX busy bit read as 0, so no tx-done pulse is lost.
        S_RX_CLR: begin
          u_we            <= 1'b1;
          u_waddr         <= A_STATUS;
          u_wdata         <= 32'h0;
          rx_pend_clr_reg <= 1'b0;
          state_reg       <= S_POLL;
        end
        S_TX_WR: begin
          if (grant_found) begin
            u_we      <= 1'b1;
            u_waddr   <= A_TXDATA;
            u_wdata   <= {24'h0, grant_data};
            req_ready <= N_REQ'(1) << grant_idx;
            rr_reg    <= grant_idx;
            tx_busy   <= 1'b1;
            state_reg <= S_GAP;
          end else begin
            // Requester withdrew its byte: skip the write and keep polling.
            state_reg <= S_POLL;
          end
        end
        S_GAP:   state_reg <= S_POLL;
        default: state_reg <= S_INIT_BAUD;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_rx_sched.sv
// Bench for uart_tx_rx_sched: a small UART register model plus queues of
// expected register writes and received bytes, checked as the DUT emits them.
module tb_uart_tx_rx_sched;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rstn = 1'b0;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]   req_ready;
  logic           rx_valid;
  logic [7:0]     rx_data;
  logic           u_we;
  logic [7:0]     u_waddr;
  logic [31:0]    u_wdata;
  logic [7:0]     u_raddr;
  logic [31:0]    u_rdata = 32'h0;
  logic           init_done;
  logic           tx_busy;

  int tests = 0;
  int fails = 0;

  // Requester k is valid while its arm toggle differs from its served toggle.
  logic [N-1:0] arm_tog = '0;
  logic [N-1:0] got_tog = '0;
  assign req_valid = arm_tog ^ got_tog;

  // UART register model.
  logic       m_busy = 1'b0;
  logic       m_st1 = 1'b0;
  logic [7:0] m_rxd = 8'h00;
  int         m_cnt = 0;
  logic       rx_set = 1'b0;
  logic [7:0] rx_byte = 8'h00;

  logic [7:0]   q_addr[$];
  logic [31:0]  q_data[$];
  logic [N-1:0] q_ready[$];
  logic [7:0]   q_rx[$];

  uart_tx_rx_sched #(.N_REQ(N), .BAUD_DIV(32'h1B8), .CTRL_INIT(32'h3)) dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .rx_valid(rx_valid), .rx_data(rx_data),
    .u_we(u_we), .u_waddr(u_waddr), .u_wdata(u_wdata), .u_raddr(u_raddr),
    .u_rdata(u_rdata), .init_done(init_done), .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (u_we && u_waddr == 8'h0C) begin
      m_busy <= 1'b1;
      m_cnt  <= 20;
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) m_busy <= 1'b0;
    end
    if (rx_set) begin
      m_st1 <= 1'b1;
      m_rxd <= rx_byte;
    end else if (u_we && u_waddr == 8'h04 && !u_wdata[1]) begin
      m_st1 <= 1'b0;
    end
    u_rdata <= (u_raddr == 8'h04) ? {30'h0, m_st1, m_busy} :
               (u_raddr == 8'h10) ? {24'h0, m_rxd} : 32'h0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Output monitor: every write and rx pulse must match the head of its queue.
  always @(negedge clk) begin
    if (rstn) begin
      if (req_ready != '0) check("ready_with_txwrite", {23'h0, u_we, u_waddr}, {23'h0, 1'b1, 8'h0C});
      got_tog <= got_tog ^ req_ready;
      if (u_we) begin
        tests++;
        assert (q_addr.size() != 0) else begin
          fails++;
          $error("FAIL unexpected_write observed addr=%0h data=%0h expected=none", u_waddr, u_wdata);
        end
        if (q_addr.size() != 0) begin
          check("waddr", {24'h0, u_waddr}, {24'h0, q_addr.pop_front()});
          check("wdata", u_wdata, q_data.pop_front());
          check("req_ready", {28'h0, req_ready}, {28'h0, q_ready.pop_front()});
        end
        if (u_waddr == 8'h04) check("clr_only_when_idle", {31'h0, m_busy}, 32'h0);
      end
      if (rx_valid) begin
        tests++;
        assert (q_rx.size() != 0) else begin
          fails++;
          $error("FAIL unexpected_rx_valid observed data=%0h expected=none", rx_data);
        end
        if (q_rx.size() != 0) check("rx_data", {24'h0, rx_data}, {24'h0, q_rx.pop_front()});
      end
    end
  end

  task automatic expect_wr(input logic [7:0] a, input logic [31:0] d, input logic [N-1:0] r);
    q_addr.push_back(a);
    q_data.push_back(d);
    q_ready.push_back(r);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((q_addr.size() != 0 || q_rx.size() != 0) && n < 600) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check({tag, "_drained"}, q_addr.size() + q_rx.size(), 32'h0);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((tx_busy || m_busy) && n < 600) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_tx_busy_cleared"}, {31'h0, tx_busy}, 32'h0);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_we"}, {31'h0, u_we}, 32'h0);
    check({tag, "_waddr"}, {24'h0, u_waddr}, 32'h0);
    check({tag, "_wdata"}, u_wdata, 32'h0);
    check({tag, "_raddr"}, {24'h0, u_raddr}, 32'h4);
    check({tag, "_ready"}, {28'h0, req_ready}, 32'h0);
    check({tag, "_rx"}, {23'h0, rx_valid, rx_data}, 32'h0);
    check({tag, "_flags"}, {30'h0, init_done, tx_busy}, 32'h0);
  endtask

  task automatic inject_rx(input logic [7:0] b);
    @(negedge clk);
    rx_byte = b;
    rx_set  = 1'b1;
    @(negedge clk);
    rx_set  = 1'b0;
  endtask

  initial begin
    int n;
    // Reset values and init sequence.
    repeat (3) @(negedge clk);
    check_reset("reset");
    expect_wr(8'h08, 32'h1B8, '0);
    expect_wr(8'h00, 32'h3, '0);
    rstn = 1'b1;
    drain("init");
    check("init_done", {31'h0, init_done}, 32'h1);
    check("poll_raddr", {24'h0, u_raddr}, 32'h4);

    // Round robin from the reset pointer, then wrap back to requester 0.
    req_data = {8'h40, 8'h30, 8'h20, 8'h10};
    expect_wr(8'h0C, 32'h10, 4'b0001);
    expect_wr(8'h0C, 32'h20, 4'b0010);
    expect_wr(8'h0C, 32'h30, 4'b0100);
    expect_wr(8'h0C, 32'h40, 4'b1000);
    arm_tog = arm_tog ^ 4'b1111;
    drain("rr4");
    expect_wr(8'h0C, 32'h10, 4'b0001);
    arm_tog = arm_tog ^ 4'b0001;
    drain("rr_wrap");

    // Pointer at 0: requester 2 beats requester 0.
    req_data = {8'h40, 8'h32, 8'h20, 8'h11};
    expect_wr(8'h0C, 32'h32, 4'b0100);
    expect_wr(8'h0C, 32'h11, 4'b0001);
    arm_tog = arm_tog ^ 4'b0101;
    drain("rr_prio");

    // Single byte on an idle UART.
    wait_idle("pre_single");
    req_data[7:0] = 8'h41;
    expect_wr(8'h0C, 32'h41, 4'b0001);
    arm_tog = arm_tog ^ 4'b0001;
    drain("single");
    check("tx_busy_set", {31'h0, tx_busy}, 32'h1);
    wait_idle("single");

    // Received byte on an idle transmitter: deliver once, then clear STATUS.
    expect_wr(8'h04, 32'h0, '0);
    q_rx.push_back(8'h5A);
    inject_rx(8'h5A);
    drain("rx_idle");
    repeat (20) @(negedge clk);
    check("rx_data_held", {24'h0, rx_data}, 32'h5A);

    // Received byte while transmitting: clear waits for the busy bit to drop.
    req_data[15:8] = 8'h77;
    expect_wr(8'h0C, 32'h77, 4'b0010);
    arm_tog = arm_tog ^ 4'b0010;
    drain("tx_for_rx");
    expect_wr(8'h04, 32'h0, '0);
    q_rx.push_back(8'hA5);
    inject_rx(8'hA5);
    drain("rx_busy");
    wait_idle("rx_busy");

    // Reset while the FSM sits in the TX write state.
    req_data[23:16] = 8'h99;
    arm_tog = arm_tog ^ 4'b0100;
    n = 0;
    while (dut.state_reg != 4'd9 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("reached_tx_wr", {28'h0, dut.state_reg}, 32'h9);
    rstn = 1'b0;
    #1;
    check_reset("midreset");
    arm_tog = arm_tog ^ 4'b0100;
    @(negedge clk);
    expect_wr(8'h08, 32'h1B8, '0);
    expect_wr(8'h00, 32'h3, '0);
    rstn = 1'b1;
    drain("reinit");

    // Pointer back at N-1 after reset: requester 0 goes before requester 3.
    req_data = {8'hD3, 8'h30, 8'h20, 8'h50};
    expect_wr(8'h0C, 32'h50, 4'b0001);
    expect_wr(8'h0C, 32'hD3, 4'b1000);
    arm_tog = arm_tog ^ 4'b1001;
    drain("rr_after_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
